// File: rtl/ysyx_23060124_scoreboard.sv
// Issue scoreboard between IDU and EXU: tracks pending register writes and the
// number of in-flight instructions, and blocks issue on RAW/WAW, serial and full hazards.
module ysyx_23060124_scoreboard #(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_pre_valid,
  output logic        o_pre_ready,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [4:0]  i_rd,
  input  logic        i_wen,
  input  logic        i_serial,
  output logic        o_post_valid,
  input  logic        i_post_ready,
  input  logic        i_wb_valid,
  input  logic        i_wb_wen,
  input  logic [4:0]  i_wb_rd,
  input  logic        i_flush,
  output logic [31:0] o_busy,
  output logic [2:0]  o_inflight,
  output logic        o_stall
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_INFLIGHT);

  logic [31:0] r_busy;
  logic [2:0]  r_inflight;

  logic [31:0] w_clr_vec;
  logic [31:0] w_set_vec;
  logic [31:0] w_eff_busy;
  logic [31:0] w_busy_nxt;
  logic        w_hazard;
  logic        w_issue;
  logic        w_wb_eff;

  always_comb begin
    w_clr_vec = '0;
    if (i_wb_valid && i_wb_wen && (i_wb_rd != 5'd0))
      w_clr_vec = 32'd1 << i_wb_rd;
    // A retiring write releases its register in the same cycle it is consumed.
    w_eff_busy = r_busy & ~w_clr_vec;
  end

  always_comb begin
    w_hazard = 1'b0;
    if ((i_rs1 != 5'd0) && w_eff_busy[i_rs1])            w_hazard = 1'b1;
    if ((i_rs2 != 5'd0) && w_eff_busy[i_rs2])            w_hazard = 1'b1;
    if (i_wen && (i_rd != 5'd0) && w_eff_busy[i_rd])     w_hazard = 1'b1;
    if (i_serial && (r_inflight != 3'd0))                w_hazard = 1'b1;
    if ((r_inflight == MAX_CNT) && !i_wb_valid)          w_hazard = 1'b1;
    if (i_flush)                                         w_hazard = 1'b1;
  end

  assign o_post_valid = i_pre_valid && !w_hazard;
  assign o_pre_ready  = i_post_ready && !w_hazard;
  assign o_stall      = i_pre_valid && w_hazard;
  assign w_issue      = i_pre_valid && o_pre_ready && i_post_ready;

  // Spurious writebacks with nothing in flight neither decrement nor clear.
  assign w_wb_eff = i_wb_valid && (r_inflight != 3'd0);

  always_comb begin
    w_set_vec = '0;
    if (w_issue && i_wen && (i_rd != 5'd0))
      w_set_vec = 32'd1 << i_rd;
    w_busy_nxt = ((r_busy & ~(w_wb_eff ? w_clr_vec : 32'd0)) | w_set_vec) & ~32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_busy     <= '0;
      r_inflight <= '0;
    end else if (i_flush) begin
      r_busy     <= '0;
      r_inflight <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      case ({w_issue, w_wb_eff})
        2'b10:   r_inflight <= r_inflight + 3'd1;
        2'b01:   r_inflight <= r_inflight - 3'd1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_inflight = r_inflight;

endmodule

// File: tb/tb_ysyx_23060124_scoreboard.sv
// Self-checking bench for ysyx_23060124_scoreboard: a reference model pushes the
// expected post-edge state into a queue, and each test pops and compares it.
module tb_ysyx_23060124_scoreboard;

  localparam int MAXI = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        pre_valid, post_ready, wen, serial, wb_valid, wb_wen, flush;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic        pre_ready, post_valid, stall;
  logic [31:0] busy;
  logic [2:0]  inflight;

  typedef struct packed {
    logic [31:0] busy;
    logic [2:0]  cnt;
  } st_t;

  st_t         q[$];
  st_t         e;
  logic [31:0] m_busy = '0;
  int          m_cnt  = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clock = ~clock;

  ysyx_23060124_scoreboard #(.MAX_INFLIGHT(MAXI)) dut (
    .clock(clock), .reset(reset),
    .i_pre_valid(pre_valid), .o_pre_ready(pre_ready),
    .i_rs1(rs1), .i_rs2(rs2), .i_rd(rd), .i_wen(wen), .i_serial(serial),
    .o_post_valid(post_valid), .i_post_ready(post_ready),
    .i_wb_valid(wb_valid), .i_wb_wen(wb_wen), .i_wb_rd(wb_rd),
    .i_flush(flush), .o_busy(busy), .o_inflight(inflight), .o_stall(stall)
  );

  task automatic drive(input logic pv, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic w, input logic s,
                       input logic wv, input logic ww, input logic [4:0] wr,
                       input logic fl);
    pre_valid = pv; post_ready = 1'b1; rs1 = a; rs2 = b; rd = d; wen = w;
    serial = s; wb_valid = wv; wb_wen = ww; wb_rd = wr; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  function automatic logic m_hz();
    logic [31:0] clr;
    logic [31:0] eb;
    clr = '0;
    if (wb_valid && wb_wen && wb_rd != 5'd0) clr[wb_rd] = 1'b1;
    eb = m_busy & ~clr;
    return (rs1 != 0 && eb[rs1]) || (rs2 != 0 && eb[rs2]) ||
           (wen && rd != 0 && eb[rd]) || (serial && m_cnt != 0) ||
           (m_cnt == MAXI && !wb_valid) || flush;
  endfunction

  // Advance one clock, pushing the model's expected next state.
  task automatic tick();
    st_t         x;
    logic        iss, wbe;
    logic [31:0] nb;
    int          nc;
    iss = pre_valid && post_ready && !m_hz();
    wbe = wb_valid && (m_cnt > 0);
    if (flush) begin
      nb = '0; nc = 0;
    end else begin
      nb = m_busy;
      if (wbe && wb_wen && wb_rd != 0) nb[wb_rd] = 1'b0;
      if (iss && wen && rd != 0) nb[rd] = 1'b1;
      nc = m_cnt + (iss ? 1 : 0) - (wbe ? 1 : 0);
    end
    x.busy = nb; x.cnt = 3'(nc);
    q.push_back(x);
    m_busy = nb; m_cnt = nc;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    #2;
    checks++;
    if (busy !== 32'd0 || inflight !== 3'd0) begin
      errors++; $display("FAIL reset_state busy=%h cnt=%0d want 0/0", busy, inflight);
    end
    checks++;
    if (post_valid !== 1'b1 || pre_ready !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL reset_hs pv=%b pr=%b st=%b want 1/1/0", post_valid, pre_ready, stall);
    end
    flush = 1'b1; #1;
    checks++;
    if (stall !== 1'b1 || post_valid !== 1'b0) begin
      errors++; $display("FAIL reset_flush_stall st=%b pv=%b want 1/0", stall, post_valid);
    end
    @(posedge clock); #1;
    checks++;
    if (busy !== 32'd0 || inflight !== 3'd0) begin
      errors++; $display("FAIL reset_held busy=%h cnt=%0d want 0/0", busy, inflight);
    end
    idle();
    reset = 1'b1;
  endtask

  task automatic test_raw_bypass();
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); #1;
    checks++;
    if (post_valid !== 1'b1) begin errors++; $display("FAIL raw_issue pv=%b want 1", post_valid); end
    tick(); e = q.pop_front();
    checks++;
    if (busy !== e.busy || inflight !== e.cnt || busy[5] !== 1'b1) begin
      errors++; $display("FAIL raw_set busy=%h/%h cnt=%0d/%0d", busy, e.busy, inflight, e.cnt);
    end
    drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); #1;
    checks++;
    if (stall !== 1'b1 || post_valid !== 1'b0 || pre_ready !== 1'b0) begin
      errors++; $display("FAIL raw_stall st=%b pv=%b pr=%b want 1/0/0", stall, post_valid, pre_ready);
    end
    tick(); e = q.pop_front();
    checks++;
    if (busy !== e.busy || inflight !== e.cnt) begin
      errors++; $display("FAIL raw_hold busy=%h/%h cnt=%0d/%0d", busy, e.busy, inflight, e.cnt);
    end
    wb_valid = 1'b1; wb_wen = 1'b1; wb_rd = 5'd5; #1;
    checks++;
    if (post_valid !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL raw_bypass pv=%b st=%b want 1/0", post_valid, stall);
    end
    tick(); e = q.pop_front();
    checks++;
    if (busy !== e.busy || inflight !== e.cnt || busy[5] !== 1'b0 || inflight !== 3'd1) begin
      errors++; $display("FAIL raw_clear busy=%h/%h cnt=%0d/%0d", busy, e.busy, inflight, e.cnt);
    end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    tick(); e = q.pop_front();
    idle();
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'd0, 5'd0, 5'(i), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      tick(); e = q.pop_front();
      checks++;
      if (busy !== e.busy || inflight !== e.cnt) begin
        errors++; $display("FAIL full_fill%0d busy=%h/%h cnt=%0d/%0d", i, busy, e.busy, inflight, e.cnt);
      end
    end
    checks++;
    if (inflight !== 3'd4 || busy !== 32'h1E) begin
      errors++; $display("FAIL full_count busy=%h cnt=%0d want 1e/4", busy, inflight);
    end
    drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); #1;
    checks++;
    if (pre_ready !== 1'b0 || post_valid !== 1'b0 || stall !== 1'b1) begin
      errors++; $display("FAIL full_block pr=%b pv=%b st=%b want 0/0/1", pre_ready, post_valid, stall);
    end
    tick(); e = q.pop_front();
    wb_valid = 1'b1; wb_wen = 1'b1; wb_rd = 5'd1; #1;
    checks++;
    if (pre_ready !== 1'b1 || post_valid !== 1'b1) begin
      errors++; $display("FAIL full_wb_issue pr=%b pv=%b want 1/1", pre_ready, post_valid);
    end
    tick(); e = q.pop_front();
    checks++;
    if (busy !== e.busy || inflight !== e.cnt || inflight !== 3'd4 || busy !== 32'h5C) begin
      errors++; $display("FAIL full_keep busy=%h/%h cnt=%0d/%0d", busy, e.busy, inflight, e.cnt);
    end
    for (int r = 2; r <= 6; r++) begin
      if (r == 5) continue;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'(r), 1'b0);
      tick(); e = q.pop_front();
    end
    checks++;
    if (busy !== 32'd0 || inflight !== 3'd0) begin
      errors++; $display("FAIL full_drain busy=%h cnt=%0d want 0/0", busy, inflight);
    end
    idle();
  endtask

  task automatic test_serial();
    for (int r = 8; r <= 9; r++) begin
      drive(1'b1, 5'd0, 5'd0, 5'(r), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      tick(); e = q.pop_front();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, k > 0, 1'b1, 5'(7 + k), 1'b0); #1;
      checks++;
      if (stall !== 1'b1 || post_valid !== 1'b0) begin
        errors++; $display("FAIL serial_stall%0d st=%b pv=%b cnt=%0d want 1/0", k, stall, post_valid, inflight);
      end
      tick(); e = q.pop_front();
      checks++;
      if (busy !== e.busy || inflight !== e.cnt) begin
        errors++; $display("FAIL serial_state%0d busy=%h/%h cnt=%0d/%0d", k, busy, e.busy, inflight, e.cnt);
      end
    end
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0); #1;
    checks++;
    if (inflight !== 3'd0 || post_valid !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL serial_go cnt=%0d pv=%b st=%b want 0/1/0", inflight, post_valid, stall);
    end
    tick(); e = q.pop_front();
    checks++;
    if (inflight !== 3'd1) begin errors++; $display("FAIL serial_issued cnt=%0d want 1", inflight); end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    tick(); e = q.pop_front();
    idle();
  endtask

  task automatic test_set_wins();
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick(); e = q.pop_front();
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0);
    tick(); e = q.pop_front();
    checks++;
    if (busy !== e.busy || inflight !== e.cnt || busy !== 32'h88 || inflight !== 3'd1) begin
      errors++; $display("FAIL setwin_idle busy=%h/%h cnt=%0d/%0d", busy, e.busy, inflight, e.cnt);
    end
    // Register 7 now really pending: retire it while re-issuing a write to it.
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0);
    tick(); e = q.pop_front();
    checks++;
    if (busy !== e.busy || inflight !== e.cnt || busy[7] !== 1'b1) begin
      errors++; $display("FAIL setwin_busy busy=%h/%h cnt=%0d/%0d", busy, e.busy, inflight, e.cnt);
    end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    tick(); e = q.pop_front();
    idle();
  endtask

  task automatic test_flush();
    for (int r = 4; r <= 6; r++) begin
      drive(1'b1, 5'd0, 5'd0, 5'(r), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      tick(); e = q.pop_front();
    end
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    tick(); e = q.pop_front();
    checks++;
    if (busy !== 32'hF0 || inflight !== 3'd3) begin
      errors++; $display("FAIL flush_setup busy=%h cnt=%0d want f0/3", busy, inflight);
    end
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1); #1;
    checks++;
    if (post_valid !== 1'b0 || pre_ready !== 1'b0 || stall !== 1'b1) begin
      errors++; $display("FAIL flush_noissue pv=%b pr=%b st=%b want 0/0/1", post_valid, pre_ready, stall);
    end
    tick(); e = q.pop_front();
    checks++;
    if (busy !== e.busy || inflight !== e.cnt || busy !== 32'd0 || inflight !== 3'd0) begin
      errors++; $display("FAIL flush_clear busy=%h/%h cnt=%0d/%0d", busy, e.busy, inflight, e.cnt);
    end
    idle();
  endtask

  task automatic test_zero_regs();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0); #1;
      checks++;
      if (stall !== 1'b0 || post_valid !== 1'b1) begin
        errors++; $display("FAIL zero_stall%0d st=%b pv=%b want 0/1", i, stall, post_valid);
      end
      tick(); e = q.pop_front();
      checks++;
      if (busy !== e.busy || inflight !== e.cnt || busy !== 32'd0) begin
        errors++; $display("FAIL zero_state%0d busy=%h/%h cnt=%0d/%0d", i, busy, e.busy, inflight, e.cnt);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick(); e = q.pop_front();
    checks++;
    if (busy === 32'd0 || inflight === 3'd0) begin
      errors++; $display("FAIL areset_pre busy=%h cnt=%0d want nonzero", busy, inflight);
    end
    idle();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 32'd0 || inflight !== 3'd0) begin
      errors++; $display("FAIL areset_async busy=%h cnt=%0d want 0/0", busy, inflight);
    end
    m_busy = '0; m_cnt = 0; q.delete();
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic hz;
    for (int i = 0; i < 300; i++) begin
      pre_valid  = ($urandom % 4) != 0;
      post_ready = ($urandom % 4) != 0;
      rs1 = 5'($urandom % 8); rs2 = 5'($urandom % 8); rd = 5'($urandom % 8);
      wen = ($urandom % 3) != 0; serial = ($urandom % 10) == 0;
      wb_valid = (m_cnt > 0) && (($urandom % 3) == 0);
      wb_wen = ($urandom % 4) != 0; wb_rd = 5'($urandom % 8);
      flush = ($urandom % 40) == 0;
      #1;
      hz = m_hz();
      checks++;
      if (post_valid !== (pre_valid && !hz) || pre_ready !== (post_ready && !hz) || stall !== (pre_valid && hz)) begin
        errors++; $display("FAIL b2b_hs%0d pv=%b pr=%b st=%b want hazard=%b", i, post_valid, pre_ready, stall, hz);
      end
      tick(); e = q.pop_front();
      checks++;
      if (busy !== e.busy || inflight !== e.cnt) begin
        errors++; $display("FAIL b2b_state%0d busy=%h/%h cnt=%0d/%0d", i, busy, e.busy, inflight, e.cnt);
      end
    end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    tick(); e = q.pop_front();
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    @(posedge clock); #1;
    test_raw_bypass();
    test_full();
    test_serial();
    test_set_wins();
    test_flush();
    test_zero_regs();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
